// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with registered-read or first-word-fall-through output
module sync_fifo_param #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AF_TH      = DEPTH - 2,
  parameter int AE_TH      = 2,
  parameter int FWFT       = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         wr_en,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid_out,
  output logic                         wr_ack,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         full,
  output logic                         empty,
  output logic                         almostfull,
  output logic                         almostempty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc;
  // Acceptance depends only on occupancy at the edge, so a full FIFO still reads and an empty one still writes
  always_comb begin
    wr_acc      = wr_en && (count != CW'(DEPTH));
    rd_acc      = rd_en && (count != '0);
    full        = count == CW'(DEPTH);
    empty       = count == '0;
    almostfull  = count >= CW'(AF_TH);
    almostempty = count <= CW'(AE_TH);
  end
  // Storage is left unreset; entries are only ever read after being written
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= data_in;
  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count     <= (wr_acc && !rd_acc) ? count + 1'b1 : (rd_acc && !wr_acc) ? count - 1'b1 : count;
      wr_ack    <= wr_acc;
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
    end
  if (FWFT != 0) begin : g_fwft
    // Head word is presented continuously; masked to zero while empty so reset shows zero
    always_comb begin
      data_out  = empty ? '0 : mem[rd_ptr];
      valid_out = !empty;
    end
  end else begin : g_reg
    // Registered read: head word captured on an accepted pop, valid for exactly one cycle
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        data_out  <= '0;
        valid_out <= 1'b0;
      end else begin
        if (rd_acc) data_out <= mem[rd_ptr];
        valid_out <= rd_acc;
      end
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: scoreboard bench for both output modes of sync_fifo_param
module tb_sync_fifo_param;
  typedef struct {
    int cnt;
    logic f, e, af, ae, ack, ovf, udf, v0, v1;
    logic [15:0] d1;
  } st_t;
  logic clk = 0, rst_n = 0, wr_en = 0, rd_en = 0;
  logic [15:0] data_in = 0;
  logic [15:0] d0, d1;
  logic v0, ack0, ovf0, udf0, f0, e0, af0, ae0;
  logic v1, ack1, ovf1, udf1, f1, e1, af1, ae1;
  logic [3:0] cnt0, cnt1;
  int n_vec = 0, n_err = 0;
  logic [15:0] q[$];
  logic [15:0] exp_rd[$];
  st_t exp_st[$];

  sync_fifo_param #(.DATA_WIDTH(16), .DEPTH(8), .AF_TH(6), .AE_TH(2), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(d0), .valid_out(v0), .wr_ack(ack0), .overflow(ovf0), .underflow(udf0),
    .full(f0), .empty(e0), .almostfull(af0), .almostempty(ae0), .count(cnt0));
  sync_fifo_param #(.DATA_WIDTH(16), .DEPTH(8), .AF_TH(6), .AE_TH(2), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(d1), .valid_out(v1), .wr_ack(ack1), .overflow(ovf1), .underflow(udf1),
    .full(f1), .empty(e1), .almostfull(af1), .almostempty(ae1), .count(cnt1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and predict the outcome from a plain queue model
  task automatic cycle(input logic w, input logic r, input logic [15:0] d);
    st_t s;
    logic wa, ra;
    @(negedge clk);
    wr_en = w; rd_en = r; data_in = d;
    wa = w && q.size() < 8;
    ra = r && q.size() > 0;
    if (ra) exp_rd.push_back(q.pop_front());
    if (wa) q.push_back(d);
    s.cnt = q.size();
    s.f = q.size() == 8;
    s.e = q.size() == 0;
    s.af = q.size() >= 6;
    s.ae = q.size() <= 2;
    s.ack = wa;
    s.ovf = w && !wa;
    s.udf = r && !ra;
    s.v0 = ra;
    s.v1 = q.size() != 0;
    s.d1 = q.size() != 0 ? q[0] : 16'h0;
    exp_st.push_back(s);
  endtask

  // Asynchronous reset between edges, checked before the next clock edge
  task automatic do_reset();
    @(negedge clk);
    wr_en = 0; rd_en = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_count0", cnt0, 0); chk("rst_count1", cnt1, 0);
    chk("rst_empty", e0, 1);    chk("rst_full", f0, 0);
    chk("rst_af", af0, 0);      chk("rst_ae", ae0, 1);
    chk("rst_ack", ack0, 0);    chk("rst_ovf", ovf0, 0);
    chk("rst_udf", udf0, 0);    chk("rst_valid0", v0, 0);
    chk("rst_data0", d0, 0);    chk("rst_valid1", v1, 0);
    chk("rst_udf1", udf1, 0);   chk("rst_empty1", e1, 1);
    q.delete();
    exp_rd.delete();
    #1 rst_n = 1;
  endtask

  // Monitor: sample after each rising edge and compare against queued expectations
  initial forever begin
    st_t s;
    @(posedge clk);
    #1;
    if (exp_st.size() != 0) begin
      s = exp_st.pop_front();
      chk("count0", cnt0, s.cnt);   chk("count1", cnt1, s.cnt);
      chk("full", f0, s.f);         chk("full1", f1, s.f);
      chk("empty", e0, s.e);        chk("empty1", e1, s.e);
      chk("almostfull", af0, s.af); chk("almostempty", ae0, s.ae);
      chk("wr_ack", ack0, s.ack);   chk("wr_ack1", ack1, s.ack);
      chk("overflow", ovf0, s.ovf); chk("overflow1", ovf1, s.ovf);
      chk("underflow", udf0, s.udf); chk("underflow1", udf1, s.udf);
      chk("valid_out0", v0, s.v0);
      chk("valid_out1", v1, s.v1);
      if (s.v1) chk("fwft_data", d1, s.d1);
    end
    if (v0) begin
      if (exp_rd.size() != 0) chk("rd_data", d0, exp_rd.pop_front());
      else chk("rd_unexpected", v0, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bias;
    do_reset();
    for (int i = 1; i <= 8; i++) cycle(1, 0, 16'(i));
    cycle(1, 0, 16'h0009);
    for (int i = 0; i < 9; i++) cycle(0, 1, 0);
    for (int i = 1; i <= 8; i++) cycle(1, 0, 16'(i + 16'h40));
    cycle(1, 1, 16'hAAAA);
    for (int i = 0; i < 7; i++) cycle(0, 1, 0);
    cycle(1, 1, 16'hAAAA);
    cycle(0, 1, 0);
    cycle(1, 0, 16'h1234);
    cycle(1, 0, 16'h5678);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 16'(16'h100 + i));
    for (int i = 3; i < 23; i++) cycle(1, 1, 16'(16'h100 + i));
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 16'(16'h200 + i));
    cycle(0, 0, 0);
    do_reset();
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    for (int b = 0; b < 8; b++) begin
      bias = $urandom_range(20, 80);
      for (int i = 0; i < 60; i++)
        cycle($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias - 10, 16'($urandom));
    end
    cycle(0, 0, 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The block SHALL provide parameter DATA_WIDTH, default 16, meaning width of stored words.
REQ-002 The block SHALL provide parameter DEPTH, default 8, meaning number of entries, any integer >= 2 (power of two not required).
REQ-003 The block SHALL provide parameter AF_TH, default DEPTH-2, meaning occupancy at or above which almostfull asserts, range 1..DEPTH-1.
REQ-004 The block SHALL provide parameter AE_TH, default 2, meaning occupancy at or below which almostempty asserts, range 0..DEPTH-2.
REQ-005 The block SHALL provide parameter FWFT, default 0, meaning 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 clk  input  1  rising-edge clock, single clock domain.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 data_in  input  DATA_WIDTH  write data.
REQ-009 wr_en  input  1  write request.
REQ-010 rd_en  input  1  read request (pop).
REQ-011 data_out  output  DATA_WIDTH  read data.
REQ-012 valid_out  output  1  data_out holds a valid word.
REQ-013 wr_ack  output  1  registered, previous-edge write accepted.
REQ-014 overflow  output  1  registered, previous-edge write rejected because full.
REQ-015 underflow  output  1  registered, previous-edge read rejected because empty.
REQ-016 full, empty, almostfull, almostempty  output  1 each  combinational decode of count.
REQ-017 count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Function
REQ-018 Write accepted at an edge iff wr_en=1 and count<DEPTH at that edge; data stored at wr_ptr, wr_ptr advances.
REQ-019 Read accepted at an edge iff rd_en=1 and count>0 at that edge; rd_ptr advances.
REQ-020 Pointers SHALL wrap from DEPTH-1 to 0 for any DEPTH value.
REQ-021 count SHALL be +1 on accepted write only, -1 on accepted read only, unchanged on both or neither.
REQ-022 Full with wr_en=1 and rd_en=1: read accepted, write rejected, overflow=1, count becomes DEPTH-1.
REQ-023 Empty with wr_en=1 and rd_en=1: write accepted, read rejected, underflow=1, count becomes 1.
REQ-024 wr_ack, overflow and underflow SHALL each be a one-cycle pulse per qualifying edge, 0 otherwise.
REQ-025 full=(count==DEPTH); empty=(count==0); almostfull=(count>=AF_TH); almostempty=(count<=AE_TH).
REQ-026 FWFT=0: on an accepted read, data_out SHALL load the head word at that edge (latency 1), valid_out=1 for that following cycle only; otherwise data_out holds its value and valid_out=0.
REQ-027 FWFT=1: data_out SHALL continuously present the head word and valid_out SHALL equal !empty; an accepted read exposes the next word the following cycle.
REQ-028 Storage array SHALL not be reset; its contents are don't-care until written.

Reset
REQ-029 rst_n=0 SHALL immediately, regardless of clk, force count=0, pointers=0, data_out=0, valid_out=0, wr_ack=0, overflow=0, underflow=0, empty=1, full=0, almostfull=0, almostempty=1.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries; first post-reset read of an unwritten FIFO SHALL underflow.
REQ-031 Writes/reads SHALL resume on the first rising edge with rst_n=1.

Verification (DATA_WIDTH=16, DEPTH=8, AF_TH=6, AE_TH=2)
REQ-032 Reset, then 8 writes 0x0001..0x0008 -> wr_ack each cycle, count 1..8, almostempty drops at count 3, almostfull at 6, full at 8; 9th write -> overflow=1, count stays 8.
REQ-033 From full, FWFT=0, 8 reads -> data_out 0x0001..0x0008 one cycle after each read with valid_out=1; 9th read -> underflow=1, empty=1.
REQ-034 Full, wr_en=rd_en=1 with data_in=0xAAAA -> overflow=1, count=7; empty, same stimulus -> underflow=1, wr_ack=1, count=1.
REQ-035 FWFT=1, write 0x1234 then 0x5678 -> data_out=0x1234, valid_out=1 before any read; one read -> data_out=0x5678 next cycle; second read -> valid_out=0.
REQ-036 Wrap: 20 interleaved write/read pairs of incrementing data with count held at 3 -> read order equals write order across pointer wrap, no flags except wr_ack.
REQ-037 Assert rst_n=0 between clock edges at count=5 -> count=0, empty=1, all pulse outputs 0 before next edge; subsequent read -> underflow=1.
